uriscv_lsu_fsm: RTL and testbench
=================================

Name: uriscv_lsu_fsm

Overview:
Sequential load/store unit for the uriscv core. It accepts one decoded load/store per handshake and computes the effective address. It drives a single-outstanding word-wide memory bus with a request/ack handshake and, optionally, splits misaligned accesses into two aligned word beats. It returns aligned and sign/zero-extended load data to writeback, and flags misalignment and bus timeouts.

Parameters:
SUPPORT_MISALIGNED, 1, 1 = split misaligned LH/LHU/SH/LW/SW into two word beats; 0 = raise fault_misaligned_o with no bus access
TIMEOUT_CYCLES, 255, maximum wait for mem_ack_i per beat; 0 disables the timeout (counter width = clog2(TIMEOUT_CYCLES+1))

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
valid_i  in  1  request valid
ready_o  out  1  unit idle, can accept
opcode_i  in  32  instruction word
rs1_val_i  in  32  base register
rs2_val_i  in  32  store data register
mem_rd_o  out  1  read request, held until ack
mem_wr_o  out  4  byte write strobes, held until ack
mem_addr_o  out  32  word-aligned address ([1:0]=0)
mem_data_o  out  32  lane-positioned store data
mem_ack_i  in  1  beat complete; mem_data_i valid for reads
mem_data_i  in  32  read data
done_o  out  1  one-cycle completion pulse
result_o  out  32  load result (0 for stores/non-LS), valid with done_o
fault_misaligned_o  out  1  misaligned fault, with done_o
fault_bus_o  out  1  timeout fault, with done_o
fault_addr_o  out  32  effective address of faulting op, with done_o

Behaviour:
- Reset (async, any state): state IDLE. mem_rd_o/mem_wr_o/mem_addr_o/mem_data_o/done_o/result_o/faults/fault_addr_o = 0; ready_o = 1 (ready_o == state IDLE).
- States: IDLE, BEAT0, BEAT1, DONE.
- Accept on valid_i && ready_o. Register the effective address and operation:
  - EA = rs1 + sext(imm); S-imm for stores (opcode[6:2]=01000), I-imm for loads (00000).
  - Decoded ops: LB, LH, LW, LBU, LHU, SB, SH, SW via func3.
- Non-load/store or undefined func3: IDLE->DONE, no bus access, result 0, no fault.
- Misalignment: EA[0] for halfword ops, |EA[1:0] for word ops; bytes never misaligned.
  - SUPPORT_MISALIGNED=0 and misaligned: IDLE->DONE with fault_misaligned_o=1 and fault_addr_o=EA; no bus access.
- Lane mask L = (size mask 1/3/F) << EA[1:0], 8 bits wide. Beat0 lanes L[3:0]; beat1 lanes L[7:4]. Beat1 exists only if L[7:4]≠0.
- Store data: 64-bit D = rs2 << 8*EA[1:0]; beat0 drives D[31:0], beat1 drives D[63:32]. mem_wr_o = lane bits; mem_rd_o = 0.
- Load: mem_rd_o=1, mem_wr_o=0.
- BEAT0: addr = {EA[31:2],2'b00}. On mem_ack_i, capture mem_data_i into lo; go to BEAT1 if a second beat exists, else DONE.
- BEAT1: addr = BEAT0 addr + 4 (wraps modulo 2^32). On ack, capture into hi; go to DONE.
- Bus outputs are stable from the first cycle of a beat until the ack cycle inclusive, and are 0 in IDLE/DONE.
- Load result: R = {hi,lo} >> 8*EA[1:0]. LB/LH sign-extend R[7:0]/R[15:0]; LBU/LHU zero-extend; LW uses R[31:0].
- DONE: done_o=1 for exactly one cycle with result and faults valid; next state IDLE. Outputs return to 0 afterwards.
- Latency (aligned, ack in first beat cycle): accept cycle N, bus request at N+1, done_o at N+2. Split access: done_o at N+3 minimum.
- Timeout (TIMEOUT_CYCLES>0):
  - A per-beat counter clears on beat entry and increments each cycle without an ack.
  - When it reaches TIMEOUT_CYCLES with no ack, drop the request and go to DONE with fault_bus_o=1, fault_addr_o=EA, result 0.
  - A beat0 timeout skips beat1.
  - An ack in the same cycle the limit is reached wins (no fault).
- A write half-completed before a beat1 timeout is not rolled back.
- valid_i while not ready is ignored (no queueing).

Test Plan:
- LW, rs1=0x1000, imm=4, ack same cycle, mem_data_i=0xDEADBEEF -> mem_addr_o=0x1004 at N+1, done_o at N+2, result_o=0xDEADBEEF.
- LB EA=0x2003, data 0x80FFFFFF -> result_o=0xFFFFFF80; LBU same address -> result_o=0x00000080.
- SW rs2=0x11223344 at EA=0x3002, SUPPORT_MISALIGNED=1 -> beat0 addr 0x3000, wr=1100, data 0x33440000; beat1 addr 0x3004, wr=0011, data 0x00001122; done_o at N+3.
- LH EA=0x4001, SUPPORT_MISALIGNED=0 -> no mem_rd_o, done_o at N+1 with fault_misaligned_o=1, fault_addr_o=0x4001.
- TIMEOUT_CYCLES=4, LW with no ack -> mem_rd_o held 4 cycles then deasserted, done_o with fault_bus_o=1, result_o=0.
- Assert rst_i mid-BEAT0 -> same cycle: mem_rd_o=0, ready_o=1, no done_o. A subsequent SB EA=0x5001 rs2=0xAB -> wr=0010, data 0x0000AB00.

Source files
------------

// File: rtl/uriscv_lsu_fsm.sv
// uriscv_lsu_fsm: sequential load/store unit with split misaligned beats and bus timeout
module uriscv_lsu_fsm #(
    parameter int SUPPORT_MISALIGNED = 1,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] opcode_i,
    input  logic [31:0] rs1_val_i,
    input  logic [31:0] rs2_val_i,
    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        fault_misaligned_o,
    output logic        fault_bus_o,
    output logic [31:0] fault_addr_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TL = TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0;

    logic [1:0]    state;
    logic [31:0]   ea, lo, hi;
    logic [2:0]    f3;
    logic          ld, fm, fb;
    logic [7:0]    lanes;
    logic [63:0]   sdata;
    logic [CW-1:0] cnt;

    logic [4:0]  opc;
    logic [2:0]  f3_n;
    logic        is_ld, is_st, ok, mis, split_fault, beat, timeout;
    logic [31:0] imm, ea_n, base, r, ext;
    logic [3:0]  szm;
    logic [7:0]  lanes_n;
    logic [63:0] sdata_n;
    logic        unused_bits;

    assign unused_bits = ^{opcode_i[19:15], opcode_i[1:0]};
    assign opc     = opcode_i[6:2];
    assign f3_n    = opcode_i[14:12];
    assign is_ld   = opc == 5'b00000;
    assign is_st   = opc == 5'b01000;
    assign ok      = (is_ld && f3_n != 3'd3 && f3_n != 3'd6 && f3_n != 3'd7) ||
                     (is_st && !f3_n[2] && f3_n[1:0] != 2'd3);
    assign imm     = is_st ? {{20{opcode_i[31]}}, opcode_i[31:25], opcode_i[11:7]}
                           : {{20{opcode_i[31]}}, opcode_i[31:20]};
    assign ea_n    = rs1_val_i + imm;
    assign szm     = f3_n[1:0] == 2'd0 ? 4'h1 : f3_n[1:0] == 2'd1 ? 4'h3 : 4'hF;
    assign mis     = (f3_n[1:0] == 2'd1 && ea_n[0]) || (f3_n[1:0] == 2'd2 && ea_n[1:0] != 2'b00);
    assign split_fault = mis && SUPPORT_MISALIGNED == 0;
    assign lanes_n = {4'h0, szm} << ea_n[1:0];
    assign sdata_n = {32'h0, rs2_val_i} << {ea_n[1:0], 3'b000};

    assign beat    = state == BEAT0 || state == BEAT1;
    assign timeout = TIMEOUT_CYCLES != 0 && !mem_ack_i && cnt == CW'(TL);
    assign base    = {ea[31:2], 2'b00};

    // Accept an op, walk its one or two word beats, then present the result for one cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            ea    <= '0;
            lo    <= '0;
            hi    <= '0;
            f3    <= '0;
            ld    <= 1'b0;
            fm    <= 1'b0;
            fb    <= 1'b0;
            lanes <= '0;
            sdata <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (valid_i) begin
                    ea    <= ea_n;
                    f3    <= f3_n;
                    ld    <= is_ld && ok;
                    lanes <= lanes_n;
                    sdata <= sdata_n;
                    fm    <= ok && split_fault;
                    fb    <= 1'b0;
                    cnt   <= '0;
                    state <= (!ok || split_fault) ? DONE : BEAT0;
                end
                BEAT0: if (mem_ack_i) begin
                    lo    <= mem_data_i;
                    cnt   <= '0;
                    state <= lanes[7:4] != 4'h0 ? BEAT1 : DONE;
                end else if (timeout) begin
                    fb    <= 1'b1;
                    state <= DONE;
                end else begin
                    cnt   <= cnt + CW'(1);
                end
                BEAT1: if (mem_ack_i) begin
                    hi    <= mem_data_i;
                    state <= DONE;
                end else if (timeout) begin
                    fb    <= 1'b1;
                    state <= DONE;
                end else begin
                    cnt   <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign r   = 32'({hi, lo} >> {ea[1:0], 3'b000});
    assign ext = f3 == 3'd0 ? {{24{r[7]}}, r[7:0]} :
                 f3 == 3'd1 ? {{16{r[15]}}, r[15:0]} :
                 f3 == 3'd4 ? {24'h0, r[7:0]} :
                 f3 == 3'd5 ? {16'h0, r[15:0]} : r;

    assign ready_o            = state == IDLE;
    assign mem_rd_o           = beat && ld;
    assign mem_wr_o           = state == BEAT0 && !ld ? lanes[3:0] :
                                state == BEAT1 && !ld ? lanes[7:4] : 4'h0;
    assign mem_addr_o         = state == BEAT0 ? base : state == BEAT1 ? base + 32'd4 : 32'h0;
    assign mem_data_o         = state == BEAT0 && !ld ? sdata[31:0] :
                                state == BEAT1 && !ld ? sdata[63:32] : 32'h0;
    assign done_o             = state == DONE;
    assign result_o           = done_o && ld && !fm && !fb ? ext : 32'h0;
    assign fault_misaligned_o = done_o && fm;
    assign fault_bus_o        = done_o && fb;
    assign fault_addr_o       = done_o && (fm || fb) ? ea : 32'h0;
endmodule

// File: tb/tb_uriscv_lsu_fsm.sv
// tb_uriscv_lsu_fsm: directed scoreboard bench for the load/store unit
module tb_uriscv_lsu_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        valid = 1'b0, valid0 = 1'b0, ack = 1'b0;
    logic [31:0] opcode = '0, rs1 = '0, rs2 = '0, mdata = '0;

    logic        ready, rd, done, fm, fb;
    logic [3:0]  wr;
    logic [31:0] addr, wdata, result, fa;
    logic        ready0, rd0, done0, fm0, fb0;
    logic [3:0]  wr0;
    logic [31:0] addr0, wdata0, result0, fa0;

    uriscv_lsu_fsm #(.SUPPORT_MISALIGNED(1), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
        .opcode_i(opcode), .rs1_val_i(rs1), .rs2_val_i(rs2),
        .mem_rd_o(rd), .mem_wr_o(wr), .mem_addr_o(addr), .mem_data_o(wdata),
        .mem_ack_i(ack), .mem_data_i(mdata), .done_o(done), .result_o(result),
        .fault_misaligned_o(fm), .fault_bus_o(fb), .fault_addr_o(fa)
    );

    uriscv_lsu_fsm #(.SUPPORT_MISALIGNED(0), .TIMEOUT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid0), .ready_o(ready0),
        .opcode_i(opcode), .rs1_val_i(rs1), .rs2_val_i(rs2),
        .mem_rd_o(rd0), .mem_wr_o(wr0), .mem_addr_o(addr0), .mem_data_o(wdata0),
        .mem_ack_i(ack), .mem_data_i(mdata), .done_o(done0), .result_o(result0),
        .fault_misaligned_o(fm0), .fault_bus_o(fb0), .fault_addr_o(fa0)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        m;
        logic        b;
        logic [31:0] a;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic exp_t mk(input logic [31:0] res, input logic m, input logic b, input logic [31:0] a);
        exp_t e;
        e.res = res;
        e.m = m;
        e.b = b;
        e.a = a;
        return e;
    endfunction

    function automatic logic [31:0] enc_ld(input logic [2:0] f, input logic [11:0] i);
        return {i, 5'd1, f, 5'd2, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_st(input logic [2:0] f, input logic [11:0] i);
        return {i[11:5], 5'd2, 5'd1, f, i[4:0], 7'b0100011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e, input bit to0);
        opcode = op;
        rs1 = a;
        rs2 = b;
        if (to0) valid0 = 1'b1;
        else valid = 1'b1;
        q.push_back(e);
        tick();
        valid = 1'b0;
        valid0 = 1'b0;
    endtask

    task automatic beat_ack(input logic [31:0] d);
        ack = 1'b1;
        mdata = d;
        tick();
        ack = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic d, input logic [31:0] r,
                              input logic m, input logic b, input logic [31:0] a);
        exp_t e;
        chk({tag, ".done"}, {31'h0, d}, 32'h1);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.scoreboard: observed empty queue expected entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, ".result"}, r, e.res);
            chk({tag, ".fault_mis"}, {31'h0, m}, {31'h0, e.m});
            chk({tag, ".fault_bus"}, {31'h0, b}, {31'h0, e.b});
            chk({tag, ".fault_addr"}, a, e.a);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst.ready", {31'h0, ready}, 32'h1);
        chk("rst.rd", {31'h0, rd}, 32'h0);
        chk("rst.wr", {28'h0, wr}, 32'h0);
        chk("rst.addr", addr, 32'h0);
        chk("rst.done", {31'h0, done}, 32'h0);
        chk("rst.result", result, 32'h0);
        rst = 1'b0;
        tick();

        issue(enc_ld(3'd2, 12'h004), 32'h1000, 32'h0, mk(32'hDEADBEEF, 1'b0, 1'b0, 32'h0), 1'b0);
        chk("lw.rd", {31'h0, rd}, 32'h1);
        chk("lw.addr", addr, 32'h1004);
        chk("lw.ready", {31'h0, ready}, 32'h0);
        beat_ack(32'hDEADBEEF);
        check_done("lw", done, result, fm, fb, fa);
        tick();
        chk("lw.idle_done", {31'h0, done}, 32'h0);
        chk("lw.idle_ready", {31'h0, ready}, 32'h1);

        issue(enc_ld(3'd0, 12'h003), 32'h2000, 32'h0, mk(32'hFFFFFF80, 1'b0, 1'b0, 32'h0), 1'b0);
        chk("lb.addr", addr, 32'h2000);
        beat_ack(32'h80FFFFFF);
        check_done("lb", done, result, fm, fb, fa);
        tick();
        issue(enc_ld(3'd4, 12'h003), 32'h2000, 32'h0, mk(32'h00000080, 1'b0, 1'b0, 32'h0), 1'b0);
        beat_ack(32'h80FFFFFF);
        check_done("lbu", done, result, fm, fb, fa);
        tick();

        issue(enc_st(3'd2, 12'h002), 32'h3000, 32'h11223344, mk(32'h0, 1'b0, 1'b0, 32'h0), 1'b0);
        chk("sw.b0.addr", addr, 32'h3000);
        chk("sw.b0.wr", {28'h0, wr}, 32'hC);
        chk("sw.b0.data", wdata, 32'h33440000);
        chk("sw.b0.rd", {31'h0, rd}, 32'h0);
        beat_ack(32'h0);
        chk("sw.b1.addr", addr, 32'h3004);
        chk("sw.b1.wr", {28'h0, wr}, 32'h3);
        chk("sw.b1.data", wdata, 32'h00001122);
        chk("sw.b1.done", {31'h0, done}, 32'h0);
        beat_ack(32'h0);
        check_done("sw", done, result, fm, fb, fa);
        chk("sw.done.wr", {28'h0, wr}, 32'h0);
        chk("sw.done.addr", addr, 32'h0);
        tick();

        issue(enc_ld(3'd1, 12'h003), 32'h6000, 32'h0, mk(32'hFFFF84AA, 1'b0, 1'b0, 32'h0), 1'b0);
        chk("lh_split.b0.addr", addr, 32'h6000);
        beat_ack(32'hAABBCCDD);
        chk("lh_split.b1.addr", addr, 32'h6004);
        chk("lh_split.b1.rd", {31'h0, rd}, 32'h1);
        beat_ack(32'h11223384);
        check_done("lh_split", done, result, fm, fb, fa);
        tick();

        issue(enc_ld(3'd2, 12'h000), 32'h8000, 32'h0, mk(32'hCAFEF00D, 1'b0, 1'b0, 32'h0), 1'b0);
        valid = 1'b1;
        opcode = enc_st(3'd0, 12'h000);
        tick();
        chk("wait.addr1", addr, 32'h8000);
        chk("wait.rd1", {31'h0, rd}, 32'h1);
        tick();
        chk("wait.addr2", addr, 32'h8000);
        valid = 1'b0;
        beat_ack(32'hCAFEF00D);
        check_done("wait", done, result, fm, fb, fa);
        tick();
        chk("ignored.ready", {31'h0, ready}, 32'h1);
        tick();
        chk("ignored.wr", {28'h0, wr}, 32'h0);
        chk("ignored.rd", {31'h0, rd}, 32'h0);

        issue(enc_ld(3'd2, 12'h000), 32'h9000, 32'h0, mk(32'h12345678, 1'b0, 1'b0, 32'h0), 1'b0);
        tick();
        tick();
        tick();
        chk("ack_limit.rd", {31'h0, rd}, 32'h1);
        beat_ack(32'h12345678);
        check_done("ack_limit", done, result, fm, fb, fa);
        tick();

        issue(enc_ld(3'd2, 12'h000), 32'h7000, 32'h0, mk(32'h0, 1'b0, 1'b1, 32'h7000), 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("tmo.rd", {31'h0, rd}, 32'h1);
            tick();
        end
        check_done("tmo", done, result, fm, fb, fa);
        chk("tmo.rd_drop", {31'h0, rd}, 32'h0);
        tick();

        issue(enc_st(3'd2, 12'h002), 32'h3000, 32'h55667788, mk(32'h0, 1'b0, 1'b1, 32'h3002), 1'b0);
        beat_ack(32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("tmo_b1.wr", {28'h0, wr}, 32'h3);
            tick();
        end
        check_done("tmo_b1", done, result, fm, fb, fa);
        tick();

        issue(32'h00000013, 32'h1234, 32'h0, mk(32'h0, 1'b0, 1'b0, 32'h0), 1'b0);
        check_done("non_ls", done, result, fm, fb, fa);
        chk("non_ls.rd", {31'h0, rd}, 32'h0);
        tick();
        issue(enc_ld(3'd3, 12'h000), 32'h1000, 32'h0, mk(32'h0, 1'b0, 1'b0, 32'h0), 1'b0);
        check_done("bad_f3", done, result, fm, fb, fa);
        tick();

        issue(enc_ld(3'd1, 12'h001), 32'h4000, 32'h0, mk(32'h0, 1'b1, 1'b0, 32'h4001), 1'b1);
        check_done("mis_lh", done0, result0, fm0, fb0, fa0);
        chk("mis_lh.rd", {31'h0, rd0}, 32'h0);
        tick();
        issue(enc_st(3'd2, 12'h002), 32'h4000, 32'h1, mk(32'h0, 1'b1, 1'b0, 32'h4002), 1'b1);
        check_done("mis_sw", done0, result0, fm0, fb0, fa0);
        chk("mis_sw.wr", {28'h0, wr0}, 32'h0);
        tick();
        issue(enc_ld(3'd2, 12'h000), 32'h4000, 32'h0, mk(32'h0BADF00D, 1'b0, 1'b0, 32'h0), 1'b1);
        for (int i = 0; i < 20; i++) tick();
        chk("no_tmo.rd", {31'h0, rd0}, 32'h1);
        beat_ack(32'h0BADF00D);
        check_done("no_tmo", done0, result0, fm0, fb0, fa0);
        tick();

        issue(enc_ld(3'd2, 12'h000), 32'h1000, 32'h0, mk(32'h0, 1'b0, 1'b0, 32'h0), 1'b0);
        chk("abort.rd_before", {31'h0, rd}, 32'h1);
        rst = 1'b1;
        #1;
        chk("abort.rd", {31'h0, rd}, 32'h0);
        chk("abort.ready", {31'h0, ready}, 32'h1);
        chk("abort.done", {31'h0, done}, 32'h0);
        q.delete();
        tick();
        rst = 1'b0;
        tick();
        issue(enc_st(3'd0, 12'h001), 32'h5000, 32'h000000AB, mk(32'h0, 1'b0, 1'b0, 32'h0), 1'b0);
        chk("sb.addr", addr, 32'h5000);
        chk("sb.wr", {28'h0, wr}, 32'h2);
        chk("sb.data", wdata, 32'h0000AB00);
        beat_ack(32'h0);
        check_done("sb", done, result, fm, fb, fa);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
